// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue and flag-holding stage in front of the 32-bit ALU
// Define ALU_ISSUE_COND_EN to evaluate ARM condition codes; otherwise every op is treated as AL.
module alu_issue #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_opcode,
   input  logic [3:0]  in_cond,
   input  logic        in_s,
   input  logic [31:0] in_rn,
   input  logic [31:0] in_op2,
   input  logic [3:0]  in_rd,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_invert_a,
   output logic        alu_invert_b,
   output logic        alu_is_logic,
   output logic        alu_logic_func_idx,
   output logic        alu_cin,
   input  logic [31:0] alu_result,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_c,
   input  logic        alu_v,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_rd,
   output logic        out_we,
   output logic        out_illegal,
   output logic [3:0]  flags_nzcv
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7;
   localparam logic [3:0] OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11;
   localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15;
   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  op_q, rd_q, cnt;
   logic [31:0] rn_q, op2_q;
   logic        s_q, skip_q, illegal_q, pend;
   logic        in_illegal, cond_pass;
   logic        d_is_logic, d_idx, d_inv_a, d_inv_b, d_zero_a, d_cin, d_we, d_flag_upd;

`ifdef ALU_ISSUE_COND_EN
   function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'd0:    cond_check = z;
         4'd1:    cond_check = !z;
         4'd2:    cond_check = c;
         4'd3:    cond_check = !c;
         4'd4:    cond_check = n;
         4'd5:    cond_check = !n;
         4'd6:    cond_check = v;
         4'd7:    cond_check = !v;
         4'd8:    cond_check = c && !z;
         4'd9:    cond_check = !c || z;
         4'd10:   cond_check = (n == v);
         4'd11:   cond_check = (n != v);
         4'd12:   cond_check = !z && (n == v);
         4'd13:   cond_check = z || (n != v);
         4'd14:   cond_check = 1'b1;
         default: cond_check = 1'b0;
      endcase
   endfunction
   assign cond_pass = cond_check(in_cond, flags_nzcv);
`else
   logic cond_unused;
   assign cond_unused = ^in_cond;
   assign cond_pass   = 1'b1;
`endif

   assign in_illegal = (in_opcode == OP_EOR) || (in_opcode == OP_TEQ);
   assign d_we       = !((op_q == OP_TST) || (op_q == OP_CMP) || (op_q == OP_CMN));
   assign d_flag_upd = s_q || !d_we;

   // ALU control decode of the held opcode; carry-in ops use the flags held at accept
   always_comb begin
      d_is_logic = 1'b0;
      d_idx      = 1'b0;
      d_inv_a    = 1'b0;
      d_inv_b    = 1'b0;
      d_zero_a   = 1'b0;
      d_cin      = 1'b0;
      case (op_q)
         OP_SUB, OP_CMP: begin d_inv_b = 1'b1; d_cin = 1'b1; end
         OP_RSB:         begin d_inv_a = 1'b1; d_cin = 1'b1; end
         OP_ADC:         d_cin = flags_nzcv[1];
         OP_SBC:         begin d_inv_b = 1'b1; d_cin = flags_nzcv[1]; end
         OP_RSC:         begin d_inv_a = 1'b1; d_cin = flags_nzcv[1]; end
         OP_AND, OP_TST: d_is_logic = 1'b1;
         OP_BIC:         begin d_is_logic = 1'b1; d_inv_b = 1'b1; end
         OP_ORR:         begin d_is_logic = 1'b1; d_idx = 1'b1; end
         OP_MOV:         begin d_is_logic = 1'b1; d_idx = 1'b1; d_zero_a = 1'b1; end
         OP_MVN:         begin d_is_logic = 1'b1; d_idx = 1'b1; d_zero_a = 1'b1; d_inv_b = 1'b1; end
         default:        ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = EXEC;
         EXEC:    if (pend ? skip_q : (cnt == 4'd0)) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // First EXEC cycle loads the ALU drive (or resolves a skip); the settle count starts after it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= '0; rd_q <= '0; rn_q <= '0; op2_q <= '0; s_q <= 1'b0;
         skip_q <= 1'b0; illegal_q <= 1'b0; pend <= 1'b0; cnt <= '0;
         alu_a <= '0; alu_b <= '0; alu_invert_a <= 1'b0; alu_invert_b <= 1'b0;
         alu_is_logic <= 1'b0; alu_logic_func_idx <= 1'b0; alu_cin <= 1'b0;
         out_result <= '0; out_rd <= '0; out_we <= 1'b0; out_illegal <= 1'b0;
         flags_nzcv <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_q      <= in_opcode;
               s_q       <= in_s;
               rn_q      <= in_rn;
               op2_q     <= in_op2;
               rd_q      <= in_rd;
               illegal_q <= in_illegal;
               skip_q    <= in_illegal || !cond_pass;
               cnt       <= CNT_INIT;
               pend      <= 1'b1;
            end
            EXEC: if (pend) begin
               pend <= 1'b0;
               if (skip_q) begin
                  out_result  <= '0;
                  out_we      <= 1'b0;
                  out_illegal <= illegal_q;
                  out_rd      <= rd_q;
               end else begin
                  alu_a              <= d_zero_a ? 32'd0 : rn_q;
                  alu_b              <= op2_q;
                  alu_invert_a       <= d_inv_a;
                  alu_invert_b       <= d_inv_b;
                  alu_is_logic       <= d_is_logic;
                  alu_logic_func_idx <= d_idx;
                  alu_cin            <= d_cin;
               end
            end else if (cnt == 4'd0) begin
               out_result  <= alu_result;
               out_we      <= d_we;
               out_illegal <= 1'b0;
               out_rd      <= rd_q;
               if (d_flag_upd) begin
                  flags_nzcv[3:2] <= {alu_n, alu_z};
                  if (!d_is_logic) flags_nzcv[1:0] <= {alu_c, alu_v};
               end
            end else begin
               cnt <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural ALU model
module tb_alu_issue;
   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready, in_s;
   logic [3:0]  in_opcode, in_cond, in_rd;
   logic [31:0] in_rn, in_op2;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_invert_a, alu_invert_b, alu_is_logic, alu_logic_func_idx, alu_cin;
   logic        alu_n, alu_z, alu_c, alu_v;
   logic        out_valid, out_ready, out_we, out_illegal;
   logic [31:0] out_result;
   logic [3:0]  out_rd, flags_nzcv;

   always #5 clk = ~clk;

   alu_issue #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_cond(in_cond),
      .in_s(in_s), .in_rn(in_rn), .in_op2(in_op2), .in_rd(in_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_invert_a(alu_invert_a), .alu_invert_b(alu_invert_b),
      .alu_is_logic(alu_is_logic), .alu_logic_func_idx(alu_logic_func_idx), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
      .out_we(out_we), .out_illegal(out_illegal), .flags_nzcv(flags_nzcv)
   );

   logic [31:0] ea, eb;
   logic [32:0] sum;
   always_comb begin
      ea         = alu_invert_a ? ~alu_a : alu_a;
      eb         = alu_invert_b ? ~alu_b : alu_b;
      sum        = {1'b0, ea} + {1'b0, eb} + {32'd0, alu_cin};
      alu_result = alu_is_logic ? (alu_logic_func_idx ? (ea | eb) : (ea & eb)) : sum[31:0];
      alu_n      = alu_result[31];
      alu_z      = (alu_result == 32'd0);
      alu_c      = alu_is_logic ? 1'b0 : sum[32];
      alu_v      = alu_is_logic ? 1'b0 : ((ea[31] == eb[31]) && (sum[31] != ea[31]));
   end

   typedef struct {
      logic [31:0] result;
      logic [3:0]  rd;
      logic        we;
      logic        ill;
      logic [3:0]  nzcv;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   failed = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] result, input logic [3:0] rd, input logic we,
                               input logic ill, input logic [3:0] nzcv, input int lat);
      exp_t e;
      e.result = result; e.rd = rd; e.we = we; e.ill = ill; e.nzcv = nzcv; e.lat = lat; e.acc = 0;
      return e;
   endfunction

   logic prev_valid = 1'b0;
   int   rise_cyc = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) rise_cyc = cyc;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_token", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("result",  out_result, e.result);
               check("rd",      32'(out_rd), 32'(e.rd));
               check("we",      32'(out_we), 32'(e.we));
               check("illegal", 32'(out_illegal), 32'(e.ill));
               check("nzcv",    32'(flags_nzcv), 32'(e.nzcv));
               check("latency", 32'(rise_cyc - e.acc), 32'(e.lat));
            end
         end
         prev_valid = out_valid;
      end
   end

   task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                        input logic [31:0] rn, input logic [31:0] op2, input logic [3:0] rd,
                        input logic push, input exp_t e);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #2;
         guard++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b1; in_opcode = op; in_cond = cond; in_s = s;
      in_rn = rn; in_op2 = op2; in_rd = rd;
      e.acc = cyc + 1;
      if (push) sb.push_back(e);
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb.size() != 0 || !in_ready) && guard < 100) begin
         @(posedge clk); #2;
         guard++;
      end
      if (sb.size() != 0 || !in_ready) check("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      in_valid = 1'b0; in_opcode = '0; in_cond = '0; in_s = 1'b0;
      in_rn = '0; in_op2 = '0; in_rd = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk); #2;
      check("rst_in_ready",  32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_flags",     32'(flags_nzcv), 32'd0);
      check("rst_result",    out_result, 32'd0);
      check("rst_alu_a",     alu_a, 32'd0);
      check("rst_alu_b",     alu_b, 32'd0);
      check("rst_alu_ctl",   32'({alu_invert_a, alu_invert_b, alu_is_logic, alu_logic_func_idx, alu_cin}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #2;

      issue(4'd4, 4'd14, 1'b1, 32'd5, 32'd7, 4'd1, 1'b1, mk(32'd12, 4'd1, 1'b1, 1'b0, 4'b0000, 3));
      drain();
      issue(4'd10, 4'd14, 1'b0, 32'd3, 32'd3, 4'd2, 1'b1, mk(32'd0, 4'd2, 1'b0, 1'b0, 4'b0110, 3));
      drain();
      issue(4'd2, 4'd0, 1'b0, 32'd9, 32'd4, 4'd3, 1'b1, mk(32'd5, 4'd3, 1'b1, 1'b0, 4'b0110, 3));
      drain();
`ifdef ALU_ISSUE_COND_EN
      issue(4'd2, 4'd1, 1'b0, 32'd9, 32'd4, 4'd4, 1'b1, mk(32'd0, 4'd4, 1'b0, 1'b0, 4'b0110, 1));
`else
      issue(4'd2, 4'd1, 1'b0, 32'd9, 32'd4, 4'd4, 1'b1, mk(32'd5, 4'd4, 1'b1, 1'b0, 4'b0110, 3));
`endif
      drain();
      issue(4'd5, 4'd14, 1'b1, 32'hFFFF_FFFF, 32'd0, 4'd5, 1'b1, mk(32'd0, 4'd5, 1'b1, 1'b0, 4'b0110, 3));
      drain();
      issue(4'd15, 4'd14, 1'b1, 32'h1234, 32'd0, 4'd6, 1'b1, mk(32'hFFFF_FFFF, 4'd6, 1'b1, 1'b0, 4'b1010, 3));
      drain();
      issue(4'd1, 4'd14, 1'b1, 32'hFF, 32'hF, 4'd7, 1'b1, mk(32'd0, 4'd7, 1'b0, 1'b1, 4'b1010, 1));
      drain();

      // Downstream stall: token must sit unchanged in DONE
      out_ready = 1'b0;
      issue(4'd12, 4'd14, 1'b0, 32'hF0, 32'h0F, 4'd8, 1'b1, mk(32'hFF, 4'd8, 1'b1, 1'b0, 4'b1010, 3));
      begin
         int guard = 0;
         while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid",  32'(out_valid), 32'd1);
         check("hold_result", out_result, 32'hFF);
         check("hold_rd",     32'(out_rd), 32'd8);
         check("hold_ready",  32'(in_ready), 32'd0);
      end
      @(posedge clk); #2;
      out_ready = 1'b1;
      @(posedge clk); #2;
      check("release_in_ready",  32'(in_ready), 32'd1);
      check("release_out_valid", 32'(out_valid), 32'd0);
      drain();

      // Reset while the op is settling abandons it
      issue(4'd4, 4'd14, 1'b1, 32'd1, 32'd1, 4'd9, 1'b0, mk(32'd2, 4'd9, 1'b1, 1'b0, 4'b0000, 3));
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      check("exec_rst_valid", 32'(out_valid), 32'd0);
      check("exec_rst_flags", 32'(flags_nzcv), 32'd0);
      check("exec_rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("exec_rst_no_token", 32'(out_valid), 32'd0);

      issue(4'd4, 4'd14, 1'b1, 32'h7FFF_FFFF, 32'd1, 4'd10, 1'b1, mk(32'h8000_0000, 4'd10, 1'b1, 1'b0, 4'b1001, 3));
      drain();
      issue(4'd2, 4'd14, 1'b1, 32'd3, 32'd5, 4'd11, 1'b1, mk(32'hFFFF_FFFE, 4'd11, 1'b1, 1'b0, 4'b1000, 3));
      drain();
      issue(4'd0, 4'd14, 1'b1, 32'hF0, 32'h0F, 4'd12, 1'b1, mk(32'd0, 4'd12, 1'b1, 1'b0, 4'b0100, 3));
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
